icache_loader: RTL
==================

// Module: icache_loader
// PURPOSE
// - Writer side of the ICache write port: receives a program image as a byte
//   stream, packs bytes into 16-bit instructions and writes them into ICache
//   through write_enable / write_instruction_index / write_instruction.
// - Holds the CPU (drives the Fetch/ICache not_enable path) until the image is
//   fully written, then releases it. Sits between the host link and ICache.
// PARAMETERS
// - BASE_INDEX  0     ICache index of the first instruction written
// - DEPTH       256   ICache capacity in instructions; larger length is an error
// PORTS
// - clk                      in   1   system clock, rising edge
// - rst                      in   1   asynchronous, active-high reset
// - start                    in   1   one-cycle pulse: begin a new load
// - byte_valid               in   1   byte_data is valid this cycle
// - byte_data                in   8   stream byte
// - byte_ready               out  1   loader accepts a byte this cycle
// - write_enable             out  1   one-cycle ICache write strobe
// - write_instruction_index  out  32  ICache write index
// - write_instruction        out  16  instruction to write
// - hold                     out  1   1 = CPU held (drives not_enable)
// - done                     out  1   1 = last load completed; CPU released
// - error                    out  1   1 = last load rejected (length > DEPTH)
// BEHAVIOUR
// - One clock, asynchronous active-high reset. Reset values: byte_ready=0,
//   write_enable=0, write_instruction_index=0, write_instruction=0, hold=1,
//   done=0, error=0, state=IDLE, length=0, count=0.
// - Byte accepted iff byte_valid && byte_ready. byte_ready=1 only in
//   LEN_LO, LEN_HI, DATA_LO, DATA_HI.
// - Stream format: length L (16 bits, little-endian, in instructions), then L
//   instructions, each low byte first.
// - States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, FLUSH, DONE, ERROR.
//   IDLE   : hold=1; start -> LEN_LO.
//   LEN_LO : accept -> length[7:0], -> LEN_HI.
//   LEN_HI : accept -> length[15:8]; L==0 -> DONE; L>DEPTH -> ERROR;
//            else count=0, -> DATA_LO.
//   DATA_LO: accept -> latch low byte, -> DATA_HI.
//   DATA_HI: accept -> next cycle write_enable=1 for exactly one cycle with
//            index=BASE_INDEX+count, data={hi,lo}; count++; if count+1==L
//            -> FLUSH, else -> DATA_LO.
//   FLUSH  : one cycle, lets the last ICache write land; -> DONE.
//   DONE   : done=1, hold=0; start -> LEN_LO (done=0, hold=1 next cycle).
//   ERROR  : error=1, hold=1, no writes; start -> LEN_LO (error cleared).
// - Latency: write_enable asserted the cycle after the high byte is accepted;
//   hold falls two cycles after the last byte is accepted.
// - start ignored in LEN_LO..FLUSH. done and error never both 1.
// - Index arithmetic 32-bit unsigned; count is 16 bits, L<=DEPTH so no wrap.
// - byte_valid=0 mid-load: state holds indefinitely, no timeout.
// - Reset mid-load: all outputs return to reset values immediately; already
//   written instructions remain in ICache; a new start is required.
// TESTING
// - Reset, no start -> hold=1, byte_ready=0, done=0, write_enable never 1.
// - start; bytes 03 00 11 22 33 44 55 66 -> writes idx 0:0x2211, 1:0x4433,
//   2:0x6655, one cycle each; hold=0 and done=1 two cycles after byte 0x66.
// - Same load with byte_valid toggling every other cycle -> identical writes,
//   no duplicate or missing write_enable pulses.
// - start; bytes 01 01 (L=257>256) -> error=1, hold=1, no write_enable;
//   then start; 00 00 -> done=1, hold=0, no writes.
// - rst asserted after first instruction of a 3-instruction load -> outputs at
//   reset values asynchronously; new start reload writes from idx 0 again.
// - BASE_INDEX=10, L=2 -> writes at idx 10 and 11; Fetch released at 10 after
//   hold falls, reads back written data.

Source files
------------

// File: rtl/icache_loader.sv
// icache_loader: loads a program image from a byte stream into the ICache and
// holds the CPU until the image has been written completely.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle pulse that begins a new load
//   byte_valid, byte_data     incoming stream byte
//   byte_ready                loader accepts a byte this cycle
//   write_enable              one-cycle ICache write strobe
//   write_instruction_index   ICache write index
//   write_instruction         16-bit instruction to write
//   hold                      1 while the CPU must stay stalled
//   done                      last load completed, CPU released
//   error                     last load rejected (length too large)
module icache_loader #(
    parameter int unsigned BASE_INDEX = 0,
    parameter int unsigned DEPTH      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_enable,
    output logic [31:0] write_instruction_index,
    output logic [15:0] write_instruction,
    output logic        hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] length_q;
    logic [15:0] count_q;
    logic [7:0]  lo_q;
    logic        accept;
    logic [15:0] len_full;

    assign accept   = byte_valid && byte_ready;
    // Full length as it will be once the high byte in flight is taken.
    assign len_full = {byte_data, length_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        hold       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (accept) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if (len_full == 16'd0)
                        state_d = S_DONE;
                    else if ({16'd0, len_full} > DEPTH)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                byte_ready = 1'b1;
                if (accept) state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if (count_q + 16'd1 == length_q)
                        state_d = S_FLUSH;
                    else
                        state_d = S_DATA_LO;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                hold = 1'b0;
                if (start) state_d = S_LEN_LO;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_d = S_LEN_LO;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length_q                <= 16'd0;
            count_q                 <= 16'd0;
            lo_q                    <= 8'd0;
            write_enable            <= 1'b0;
            write_instruction_index <= 32'd0;
            write_instruction       <= 16'd0;
        end else begin
            write_enable <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_LEN_LO: begin
                        length_q[7:0] <= byte_data;
                    end
                    S_LEN_HI: begin
                        length_q[15:8] <= byte_data;
                        count_q        <= 16'd0;
                    end
                    S_DATA_LO: begin
                        lo_q <= byte_data;
                    end
                    S_DATA_HI: begin
                        write_enable            <= 1'b1;
                        write_instruction_index <= BASE_INDEX + {16'd0, count_q};
                        write_instruction       <= {byte_data, lo_q};
                        count_q                 <= count_q + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
